// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Holds op encodings, FSM state codes, the iteration count and small op-decode helpers.
package muldiv_pkg;

  localparam int ITER = 32;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIVS);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULS) || (op == OP_DIVS);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the decode/register stage and the multiply/divide unit.
// Latency: n/a (wiring only).
// Backpressure: none; the requester must hold off while busy is high.
//
// master: start/op/src_a/src_b/dest out; busy/done/wb_en/wb_addr/wb_data/hi_data/div_by_zero in.
// slave:  the mirror image, used by muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [AW-1:0]    dest;
  logic             busy;
  logic             done;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] hi_data;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b, dest,
    input  busy, done, wb_en, wb_addr, wb_data, hi_data, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, dest,
    output busy, done, wb_en, wb_addr, wb_data, hi_data, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a double-width accumulator.
// Latency: combinational.
// Backpressure: none.
//
// Ports: acc (in, {high,low}), operand (in, multiplicand or divisor magnitude),
//        div_mode (in, 1 = divide step), acc_next (out).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: high half accumulates, carry becomes the new MSB after the shift.
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: remainder shifted left with the next dividend bit (low-half MSB).
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    // A zero divisor never borrows, which naturally yields an all-ones quotient.
    diff = rem_sh - {1'b0, operand};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply (MULU/MULS) and restoring divide (DIVU/DIVS) for the execute stage.
// Latency: 33 clocks from the start edge to the one-cycle done/wb_en pulse; one op per 35 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy or done are dropped.
//
// Ports: clk, reset (sync, active-high), bus (muldiv_if.slave: start/op/src_a/src_b/dest in,
//        busy/done/wb_en/wb_addr/wb_data/hi_data/div_by_zero out).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;
  logic [AW-1:0]      dest_q;
  logic [AW-1:0]      wb_addr_q;
  logic [WIDTH-1:0]   wb_data_q;
  logic [WIDTH-1:0]   hi_data_q;
  logic               dbz_q;

  // Operand magnitudes and sign flags at request time.
  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  always_comb begin
    sgn_a = op_is_signed(bus.op) & bus.src_a[WIDTH-1];
    sgn_b = op_is_signed(bus.op) & bus.src_b[WIDTH-1];
    mag_a = sgn_a ? -bus.src_a : bus.src_a;
    mag_b = sgn_b ? -bus.src_b : bus.src_b;
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    // Divide-by-zero keeps the all-ones quotient unsigned.
    quo_fix  = (neg_res && !b_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .div_mode (is_div),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      operand   <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      b_zero    <= 1'b0;
      dest_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      hi_data_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_CALC;
            cnt     <= '0;
            is_div  <= op_is_div(bus.op);
            neg_res <= sgn_a ^ sgn_b;
            neg_rem <= sgn_a;
            b_zero  <= (bus.src_b == '0);
            dest_q  <= bus.dest;
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            if (op_is_div(bus.op)) begin
              acc     <= {{WIDTH{1'b0}}, mag_a};
              operand <= mag_b;
            end else begin
              acc     <= {{WIDTH{1'b0}}, mag_b};
              operand <= mag_a;
            end
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIX: begin
          state     <= ST_DONE;
          wb_addr_q <= dest_q;
          dbz_q     <= is_div & b_zero;
          if (is_div) begin
            wb_data_q <= quo_fix;
            hi_data_q <= rem_fix;
          end else begin
            wb_data_q <= prod_fix[WIDTH-1:0];
            hi_data_q <= prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = (state == ST_CALC) || (state == ST_FIX);
  assign bus.done        = (state == ST_DONE);
  assign bus.wb_en       = (state == ST_DONE);
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.hi_data     = hi_data_q;
  assign bus.div_by_zero = dbz_q;

endmodule
